hd44780_frame_writer: RTL and testbench

//  Parametrised HD44780 frame sequencer. Holds a ROWS x COLS character buffer
//  and, on request, streams the optional init command sequence, per-row DDRAM

---
 rtl/hd44780_frame_writer.sv | 199 +++++++++++++++++++
 tb/tb_hd44780_frame_writer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_frame_writer.sv
// hd44780_frame_writer
//   Frame sequencer for an HD44780 character LCD. Holds a ROWS x COLS
//   character buffer and, when i_start is pulsed, streams the optional init
//   command sequence, one DDRAM address command per row, and every buffered
//   character of that row. Bytes are handed to a bus-timing driver over a
//   valid/ready handshake. The driver owns all enable-pulse and wait timing.
//
// Ports
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_start, i_init     frame request pulse; init sequence select (with start)
//   i_wr_en/addr/bcd/data  buffer write port (addr = row*COLS+col)
//   o_valid, i_ready    byte handshake to the driver
//   o_rs, o_q           register select (0 cmd, 1 data) and byte
//   o_busy, o_done      frame in progress; 1-cycle end-of-frame pulse
module hd44780_frame_writer #(
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 2,
  parameter logic [7:0]  FUNC_SET = 8'h38,
  parameter int unsigned AW       = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_init,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic          i_wr_bcd,
  input  logic [7:0]    i_wr_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_rs,
  output logic [7:0]    o_q,
  output logic          o_busy,
  output logic          o_done
);

  // Buffer spans the full address space so any AW-bit index is in range;
  // only the first ROWS*COLS entries are ever written or read.
  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned NCHR     = ROWS * COLS;
  localparam logic [7:0]  COLS8    = 8'(COLS);
  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [1:0]  LAST_ROW = 2'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROWADDR,
    S_CHARS,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        present_q, present_d;   // 0 = fetch cycle, 1 = byte presented
  logic [1:0]  idx_q, idx_d;           // init command index
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [7:0]  q_q, q_d;
  logic        rs_q, rs_d;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    wr_byte;
  logic [AW-1:0] rd_addr;
  logic [7:0]    row_base;
  logic [7:0]    fetch_byte;

  // ---------------------------------------------------------------------
  // Character buffer
  // ---------------------------------------------------------------------
  always_comb begin
    wr_byte = i_wr_bcd ? {4'h3, i_wr_data[3:0]} : i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h20;
      end
    end else if (i_wr_en && (32'(i_wr_addr) < NCHR)) begin
      mem_q[i_wr_addr] <= wr_byte;
    end
  end

  // ---------------------------------------------------------------------
  // Byte selection for the current fetch
  // ---------------------------------------------------------------------
  always_comb begin
    rd_addr  = AW'(32'(row_q) * COLS + 32'(col_q));
    // Odd rows live at 0x40; rows 2/3 continue the first two lines at +COLS.
    row_base = (row_q[0] ? 8'h40 : 8'h00) + (row_q[1] ? COLS8 : 8'h00);
  end

  always_comb begin
    fetch_byte = 8'h00;
    case (state_q)
      S_INIT: begin
        case (idx_q)
          2'd0:    fetch_byte = FUNC_SET;
          2'd1:    fetch_byte = 8'h0C;
          2'd2:    fetch_byte = 8'h01;
          default: fetch_byte = 8'h06;
        endcase
      end
      S_ROWADDR: fetch_byte = 8'h80 | row_base;
      S_CHARS:   fetch_byte = mem_q[rd_addr];
      default:   fetch_byte = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      present_q <= 1'b0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      q_q       <= '0;
      rs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      present_q <= present_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      q_q       <= q_d;
      rs_q      <= rs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    present_d = present_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    q_d       = q_q;
    rs_d      = rs_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = i_init ? S_INIT : S_ROWADDR;
          present_d = 1'b0;
          idx_d     = '0;
          row_d     = '0;
          col_d     = '0;
        end
      end

      S_INIT, S_ROWADDR, S_CHARS: begin
        if (!present_q) begin
          q_d       = fetch_byte;
          rs_d      = (state_q == S_CHARS);
          present_d = 1'b1;
        end else if (i_ready) begin
          // Dropping present gives the mandatory one-cycle gap (next fetch).
          present_d = 1'b0;
          case (state_q)
            S_INIT: begin
              if (idx_q == 2'd3) state_d = S_ROWADDR;
              else               idx_d   = idx_q + 2'd1;
            end
            S_ROWADDR: begin
              state_d = S_CHARS;
              col_d   = '0;
            end
            default: begin
              if (col_q == LAST_COL) begin
                if (row_q == LAST_ROW) begin
                  state_d = S_DONE;
                end else begin
                  row_d   = row_q + 2'd1;
                  state_d = S_ROWADDR;
                end
              end else begin
                col_d = col_q + 6'd1;
              end
            end
          endcase
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_valid = present_q;
    o_q     = q_q;
    o_rs    = rs_q;
    o_busy  = (state_q == S_INIT) || (state_q == S_ROWADDR) || (state_q == S_CHARS);
    o_done  = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_hd44780_frame_writer.sv
module tb_hd44780_frame_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT a: 16x2, DUT b: 20x4
  logic       start_a, init_a, wr_en_a, wr_bcd_a, ready_a;
  logic [6:0] wr_addr_a;
  logic [7:0] wr_data_a, q_a;
  logic       v_a, rs_a, busy_a, done_a;
  logic       start_b, init_b, wr_en_b, wr_bcd_b, ready_b;
  logic [6:0] wr_addr_b;
  logic [7:0] wr_data_b, q_b;
  logic       v_b, rs_b, busy_b, done_b;

  hd44780_frame_writer #(.COLS(16), .ROWS(2), .FUNC_SET(8'h38), .AW(7)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_init(init_a),
    .i_wr_en(wr_en_a), .i_wr_addr(wr_addr_a), .i_wr_bcd(wr_bcd_a), .i_wr_data(wr_data_a),
    .o_valid(v_a), .i_ready(ready_a), .o_rs(rs_a), .o_q(q_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  hd44780_frame_writer #(.COLS(20), .ROWS(4), .FUNC_SET(8'h38), .AW(7)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_init(init_b),
    .i_wr_en(wr_en_b), .i_wr_addr(wr_addr_b), .i_wr_bcd(wr_bcd_b), .i_wr_data(wr_data_b),
    .o_valid(v_b), .i_ready(ready_b), .o_rs(rs_b), .o_q(q_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  int total = 0;
  int bad   = 0;

  // Model: display contents plus the list of bytes a frame must produce.
  // Entries >= 'h1000 are buffer indices resolved when the byte is accepted;
  // others are {rs, byte}.
  logic [7:0] mbuf_a [128];
  logic [7:0] mbuf_b [128];
  int expq_a[$];
  int expq_b[$];
  int log_a[$];
  int log_b[$];
  int prev_v[2], prev_rdy[2], prev_q[2], prev_rs[2];
  int since_acc[2], frame_bytes[2], frame_last[2], done_cnt[2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cols_of(input int d); return (d == 0) ? 16 : 20; endfunction
  function automatic int rows_of(input int d); return (d == 0) ? 2 : 4;  endfunction
  function automatic int get_v(input int d);    return (d == 0) ? int'(v_a)    : int'(v_b);    endfunction
  function automatic int get_q(input int d);    return (d == 0) ? int'(q_a)    : int'(q_b);    endfunction
  function automatic int get_rs(input int d);   return (d == 0) ? int'(rs_a)   : int'(rs_b);   endfunction
  function automatic int get_busy(input int d); return (d == 0) ? int'(busy_a) : int'(busy_b); endfunction
  function automatic int get_done(input int d); return (d == 0) ? int'(done_a) : int'(done_b); endfunction
  function automatic int qsize(input int d);    return (d == 0) ? expq_a.size() : expq_b.size(); endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      mbuf_a[i] = 8'h20;
      mbuf_b[i] = 8'h20;
    end
    expq_a.delete();
    expq_b.delete();
    for (int d = 0; d < 2; d++) begin
      prev_v[d] = 0; prev_rdy[d] = 0; prev_q[d] = 0; prev_rs[d] = 0;
      since_acc[d] = 100; frame_bytes[d] = 0;
    end
  endtask

  // Per-cycle compare for one DUT, sampled on the falling edge.
  task automatic step(input int d, input int v, input int rs, input int q,
                      input int busy, input int done, input int rdy);
    int e, exp_b, exp_rs;
    if (since_acc[d] < 100) since_acc[d]++;
    chk("done_busy_excl", int'(done != 0 && busy != 0), 0);
    if (prev_v[d] != 0 && prev_rdy[d] == 0) begin
      chk("hold_valid", v, 1);
      chk("hold_q", q, prev_q[d]);
      chk("hold_rs", rs, prev_rs[d]);
    end
    if (since_acc[d] == 1) chk("gap_valid_low", v, 0);
    if (v != 0 && prev_v[d] == 0 && frame_bytes[d] > 0) chk("gap_len", since_acc[d], 2);
    if (v != 0 && rdy != 0) begin
      chk("byte_expected", int'(qsize(d) > 0), 1);
      if (qsize(d) > 0) begin
        if (d == 0) e = expq_a.pop_front(); else e = expq_b.pop_front();
        if (e >= 'h1000) begin
          exp_b  = (d == 0) ? int'(mbuf_a[e - 'h1000]) : int'(mbuf_b[e - 'h1000]);
          exp_rs = 1;
        end else begin
          exp_b  = e & 'hff;
          exp_rs = e >> 8;
        end
        chk("byte_q", q, exp_b);
        chk("byte_rs", rs, exp_rs);
      end
      if (d == 0) log_a.push_back(q); else log_b.push_back(q);
      frame_bytes[d]++;
      since_acc[d] = 0;
    end
    if (done != 0) begin
      done_cnt[d]++;
      frame_last[d]  = frame_bytes[d];
      frame_bytes[d] = 0;
    end
    prev_v[d] = v; prev_rdy[d] = rdy; prev_q[d] = q; prev_rs[d] = rs;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 2; d++) begin
          prev_v[d] = 0; frame_bytes[d] = 0; since_acc[d] = 100;
        end
      end else begin
        step(0, int'(v_a), int'(rs_a), int'(q_a), int'(busy_a), int'(done_a), int'(ready_a));
        step(1, int'(v_b), int'(rs_b), int'(q_b), int'(busy_b), int'(done_b), int'(ready_b));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (all called at posedge + #1)
  // ---------------------------------------------------------------------
  task automatic set_start(input int d, input logic s, input logic ini);
    if (d == 0) begin start_a = s; init_a = ini; end
    else        begin start_b = s; init_b = ini; end
  endtask

  task automatic wr(input int d, input int addr, input logic bcd, input logic [7:0] data);
    logic [7:0] b;
    b = bcd ? {4'h3, data[3:0]} : data;
    if (d == 0) begin
      wr_en_a = 1'b1; wr_addr_a = 7'(addr); wr_bcd_a = bcd; wr_data_a = data;
      if (addr < 32) mbuf_a[addr] = b;
    end else begin
      wr_en_b = 1'b1; wr_addr_b = 7'(addr); wr_bcd_b = bcd; wr_data_b = data;
      if (addr < 80) mbuf_b[addr] = b;
    end
    @(posedge clk); #1;
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic start_frame(input int d, input int ini);
    int cols, rows;
    cols = cols_of(d);
    rows = rows_of(d);
    if (ini != 0) begin
      if (d == 0) begin expq_a.push_back('h38); expq_a.push_back('h0C); expq_a.push_back('h01); expq_a.push_back('h06); end
      else        begin expq_b.push_back('h38); expq_b.push_back('h0C); expq_b.push_back('h01); expq_b.push_back('h06); end
    end
    for (int r = 0; r < rows; r++) begin
      if (d == 0) expq_a.push_back('h80 | ((r % 2) * 'h40 + (r / 2) * cols));
      else        expq_b.push_back('h80 | ((r % 2) * 'h40 + (r / 2) * cols));
      for (int c = 0; c < cols; c++) begin
        if (d == 0) expq_a.push_back('h1000 + r * cols + c);
        else        expq_b.push_back('h1000 + r * cols + c);
      end
    end
    if (d == 0) log_a.delete(); else log_b.delete();
    set_start(d, 1'b1, ini != 0);
    @(posedge clk); #1;
    set_start(d, 1'b0, 1'b0);
    chk("busy_cycle1", get_busy(d), 1);
    chk("valid_cycle1", get_v(d), 0);
    @(posedge clk); #1;
    chk("valid_cycle2", get_v(d), 1);
  endtask

  task automatic wait_done(input int d, input int poke, input int exp_len);
    int n;
    n = 0;
    while (get_done(d) == 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done_seen", get_done(d), 1);
    if (poke != 0 && get_done(d) != 0) begin
      set_start(d, 1'b1, 1'b0);   // lands on the DONE cycle: must be ignored
      @(posedge clk); #1;
      set_start(d, 1'b0, 1'b0);
    end else begin
      @(posedge clk); #1;
    end
    chk("queue_drained", qsize(d), 0);
    chk("busy_after_done", get_busy(d), 0);
    chk("frame_len", frame_last[d], exp_len);
  endtask

  task automatic wait_log(input int d, input int n_logged, input int exact);
    int n, sz;
    n = 0;
    forever begin
      sz = (d == 0) ? log_a.size() : log_b.size();
      if (((exact != 0) ? (sz == n_logged) : (sz >= n_logged)) && get_v(d) != 0) break;
      if (n >= 500) break;
      @(posedge clk); #1;
      n++;
    end
    chk("wait_log_in_time", int'(n < 500), 1);
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_valid", get_v(d), 0);
    chk("rst_rs", get_rs(d), 0);
    chk("rst_q", get_q(d), 0);
    chk("rst_busy", get_busy(d), 0);
    chk("rst_done", get_done(d), 0);
  endtask

  // ---------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------
  initial begin
    int lit2 [11];
    int dc;
    lit2 = '{'h38, 'h0C, 'h01, 'h06, 'h80, 'h31, 'h32, 'h3A, 'h30, 'h30, 'h20};
    start_a = 0; init_a = 0; wr_en_a = 0; wr_addr_a = '0; wr_bcd_a = 0; wr_data_a = '0; ready_a = 1;
    start_b = 0; init_b = 0; wr_en_b = 0; wr_addr_b = '0; wr_bcd_b = 0; wr_data_b = '0; ready_b = 1;
    for (int d = 0; d < 2; d++) begin frame_last[d] = 0; done_cnt[d] = 0; end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Blank frame, no init
    start_frame(0, 0);
    wait_done(0, 0, 34);
    chk("t1_byte0", log_a[0], 'h80);
    chk("t1_byte1", log_a[1], 'h20);
    chk("t1_byte17", log_a[17], 'hC0);
    chk("t1_byte33", log_a[33], 'h20);
    chk("t1_done_cnt", done_cnt[0], 1);

    // "12:00" with init
    wr(0, 0, 1'b1, 8'hF1);
    wr(0, 1, 1'b1, 8'h72);
    wr(0, 2, 1'b0, 8'h3A);
    wr(0, 3, 1'b1, 8'h00);
    wr(0, 4, 1'b1, 8'hA0);
    start_frame(0, 1);
    wait_done(0, 0, 38);
    for (int i = 0; i < 11; i++) chk("t2_seq", log_a[i], lit2[i]);

    // Ten-cycle stall while a byte is presented
    start_frame(0, 0);
    wait_log(0, 5, 0);
    ready_a = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    ready_a = 1'b1;
    wait_done(0, 0, 34);
    chk("t3_byte3", log_a[3], 'h3A);
    chk("t3_byte4", log_a[4], 'h30);

    // Overwrite addr 5 while addr 3 is presented; starts during frame ignored
    dc = done_cnt[0];
    start_frame(0, 0);
    wait_log(0, 4, 1);
    wr(0, 5, 1'b0, 8'h5A);
    set_start(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0, 1'b0);
    wait_done(0, 1, 34);
    repeat (40) begin @(posedge clk); #1; end
    chk("t4_idle_busy", get_busy(0), 0);
    chk("t4_done_once", done_cnt[0] - dc, 1);
    chk("t4_no_second_frame", log_a.size(), 34);
    chk("t4_byte5", log_a[5], 'h30);
    chk("t4_byte6", log_a[6], 'h5A);

    // Reset in the middle of an init frame
    start_frame(0, 1);
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk_reset_outputs(0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_frame(0, 0);
    wait_done(0, 0, 34);
    chk("t5_byte1", log_a[1], 'h20);
    chk("t5_byte6", log_a[6], 'h20);

    // 20x4 geometry
    wr(1, 80, 1'b0, 8'h58);
    wr(1, 79, 1'b0, 8'h41);
    wr(1, 20, 1'b1, 8'h07);
    wr(1, 0, 1'b0, 8'h42);
    start_frame(1, 0);
    wait_done(1, 0, 84);
    chk("t6_row0", log_b[0], 'h80);
    chk("t6_row1", log_b[21], 'hC0);
    chk("t6_row2", log_b[42], 'h94);
    chk("t6_row3", log_b[63], 'hD4);
    chk("t6_first", log_b[1], 'h42);
    chk("t6_row1_col0", log_b[22], 'h37);
    chk("t6_last", log_b[83], 'h41);
    chk("t6_len", log_b.size(), 84);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
